led_frame_scheduler: RTL and testbench
======================================

// Module: led_frame_scheduler
// PURPOSE
//  Shares the LED matrix display path between two frame producers (A, B).
//  Arbitrates round-robin, buffers the granted 64-bit frame and hands it to
//  the LED matrix controller with an enable/ready handshake.
//  Holds each shown frame for a minimum number of timebase ticks before
//  re-arbitrating. Sits between game/pattern logic and the matrix controller.
// PARAMETERS
//  HOLD_TICKS  3  minimum ticks a frame is held after hand-off (0 behaves as 1)
//  TICK_W      4  width of the hold counter; HOLD_TICKS < 2**TICK_W
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-low reset
//  tick         in   1   one-cycle timebase pulse (e.g. second timeout)
//  a_valid      in   1   requester A has a frame; held high until a_ack
//  a_frame      in   64  requester A frame; stable while a_valid
//  a_ack        out  1   one-cycle pulse: A's frame accepted into buffer
//  b_valid      in   1   requester B has a frame; held high until b_ack
//  b_frame      in   64  requester B frame; stable while b_valid
//  b_ack        out  1   one-cycle pulse: B's frame accepted into buffer
//  disp_ready   in   1   matrix controller can take a frame this cycle
//  disp_enable  out  1   frame offered to matrix controller
//  disp_frame   out  64  frame buffer contents driven to the controller
//  owner        out  1   0 = A, 1 = B: source of the frame in disp_frame
//  busy         out  1   high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst low, async): state IDLE, disp_frame=0, disp_enable=0, a_ack=0,
//   b_ack=0, owner=0, busy=0, hold counter=0, last_grant=B (A wins first tie).
//  States: IDLE -> LOAD -> HOLD -> IDLE.
//  IDLE: sampled at edge N:
//   - only a_valid: grant A. Only b_valid: grant B.
//   - both: grant the requester opposite last_grant.
//   - On grant at edge N: frame copied to buffer, owner and last_grant updated,
//     *_ack high for cycle N+1 only, state = LOAD.
//   - Neither valid: stay in IDLE; outputs unchanged (last frame stays on
//     disp_frame).
//  LOAD: disp_enable=1 from cycle N+1, and disp_frame=buffer.
//   - Handshake completes on the first edge with disp_enable && disp_ready.
//   - disp_enable drops the next cycle; counter clears; state = HOLD.
//   - With ready already high, enable is high for exactly 1 cycle.
//   - Ticks during LOAD are ignored.
//  HOLD: each tick increments the counter. On a tick with counter ==
//   max(HOLD_TICKS,1)-1, state = IDLE.
//   - Requests are not arbitrated in HOLD. No preemption.
//   - disp_frame and owner stay stable through HOLD and into IDLE.
//  Boundary rules:
//   - A valid that drops before grant is never acked.
//   - A new valid during *_ack is a new request.
//   - Back-to-back requests from both sides alternate, so there is no
//     starvation.
//   - Tick and handshake in the same cycle: the tick is not counted.
//   - Counter never wraps: it saturates at the terminal value, then leaves HOLD.
//   - Reset mid-LOAD/HOLD aborts at once: enable=0 and the buffer is cleared.
//  Latency: grant to disp_enable = 1 cycle. Minimum time from a grant to the
//   next grant = 2 cycles + HOLD_TICKS ticks.
// TESTING
//  1 Reset: rst low mid-LOAD -> disp_enable=0, disp_frame=0, busy=0 at once.
//  2 Single: a_valid, a_frame=64'hFF00 with ready=1 -> a_ack 1 cycle;
//    enable 1 cycle; disp_frame=64'hFF00, owner=0.
//  3 Tie: A=64'h1 and B=64'h2 held valid -> order A, B, A, B. Each frame
//    holds 3 ticks.
//  4 Ready stall: ready=0 for 5 cycles -> enable stays high with a stable
//    frame; a tick meanwhile is not counted.
//  5 Hold: tick every 10 cycles, b_valid during HOLD -> b_ack only after the
//    3rd tick.
//  6 Withdrawal: a_valid pulsed during HOLD, low before IDLE -> no a_ack, no
//    enable.

Source files
------------

// File: rtl/led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : led_frame_scheduler
// Purpose  : Round-robin sharing of the LED matrix display path between two
//            frame producers, with a tick-based minimum hold per shown frame.
// Revision : 1.0  initial release
// ============================================================================
module led_frame_scheduler #(
    parameter int HOLD_TICKS = 3,
    parameter int TICK_W     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        a_valid,
    input  logic [63:0] a_frame,
    output logic        a_ack,
    input  logic        b_valid,
    input  logic [63:0] b_frame,
    output logic        b_ack,
    input  logic        disp_ready,
    output logic        disp_enable,
    output logic [63:0] disp_frame,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // A hold of zero ticks is treated as one tick.
    localparam int                c_TERM_INT = (HOLD_TICKS < 1) ? 0 : HOLD_TICKS - 1;
    localparam logic [TICK_W-1:0] c_TERMINAL = TICK_W'(c_TERM_INT);

    state_t              r_state;
    state_t              w_nextState;
    logic [TICK_W-1:0]   r_count;
    logic [TICK_W-1:0]   w_nextCount;
    logic [63:0]         r_buffer;
    logic                r_owner;
    logic                r_lastGrant;
    logic                r_aAck;
    logic                r_bAck;
    logic                w_grantA;
    logic                w_grantB;

    // On a tie the side that did not win last time is granted.
    assign w_grantA = (r_state == ST_IDLE) && a_valid && (!b_valid ||  r_lastGrant);
    assign w_grantB = (r_state == ST_IDLE) && b_valid && (!a_valid || !r_lastGrant);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            ST_IDLE: begin
                if (w_grantA || w_grantB) begin
                    w_nextState = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (disp_ready) begin
                    w_nextState = ST_HOLD;
                    w_nextCount = '0;
                end
            end
            ST_HOLD: begin
                // Counter stops at the terminal value; that tick ends the hold.
                if (tick) begin
                    if (r_count == c_TERMINAL) begin
                        w_nextState = ST_IDLE;
                    end else begin
                        w_nextCount = r_count + TICK_W'(1);
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextCount = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buffer    <= '0;
            r_owner     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_aAck      <= 1'b0;
            r_bAck      <= 1'b0;
        end else begin
            r_aAck <= w_grantA;
            r_bAck <= w_grantB;
            if (w_grantA || w_grantB) begin
                r_buffer    <= w_grantB ? b_frame : a_frame;
                r_owner     <= w_grantB;
                r_lastGrant <= w_grantB;
            end
        end
    end

    assign a_ack       = r_aAck;
    assign b_ack       = r_bAck;
    assign disp_enable = (r_state == ST_LOAD);
    assign disp_frame  = r_buffer;
    assign owner       = r_owner;
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_led_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_frame_scheduler
// Purpose  : Directed vector bench for led_frame_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_led_frame_scheduler;

    logic        clk;
    logic        rst;
    logic        tick;
    logic        aValid;
    logic [63:0] aFrame;
    logic        aAck;
    logic        bValid;
    logic [63:0] bFrame;
    logic        bAck;
    logic        ready;
    logic        en;
    logic [63:0] frame;
    logic        owner;
    logic        busy;

    logic        zAAck;
    logic        zBAck;
    logic        zEn;
    logic [63:0] zFrame;
    logic        zOwner;
    logic        zBusy;

    int nVec;
    int nMis;

    led_frame_scheduler #(.HOLD_TICKS(3), .TICK_W(4)) dut (
        .clk(clk), .rst(rst), .tick(tick),
        .a_valid(aValid), .a_frame(aFrame), .a_ack(aAck),
        .b_valid(bValid), .b_frame(bFrame), .b_ack(bAck),
        .disp_ready(ready), .disp_enable(en), .disp_frame(frame),
        .owner(owner), .busy(busy)
    );

    // Zero-tick variant: must behave as a one-tick hold.
    led_frame_scheduler #(.HOLD_TICKS(0), .TICK_W(2)) dutZero (
        .clk(clk), .rst(rst), .tick(tick),
        .a_valid(aValid), .a_frame(aFrame), .a_ack(zAAck),
        .b_valid(bValid), .b_frame(bFrame), .b_ack(zBAck),
        .disp_ready(ready), .disp_enable(zEn), .disp_frame(zFrame),
        .owner(zOwner), .busy(zBusy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       tag;
        logic        rst;
        logic        tick;
        logic        av;
        logic [63:0] af;
        logic        bv;
        logic [63:0] bf;
        logic        rdy;
        logic        eaAck;
        logic        ebAck;
        logic        eEn;
        logic [63:0] eFrame;
        logic        eOwner;
        logic        eBusy;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(string t, logic r, logic tk, logic av, logic [63:0] af,
                              logic bv, logic [63:0] bf, logic rdy,
                              logic ea, logic eb, logic ee, logic [63:0] ef,
                              logic eo, logic ebusy);
        vec_t x;
        x.tag = t;   x.rst = r;   x.tick = tk; x.av = av; x.af = af;
        x.bv = bv;   x.bf = bf;   x.rdy = rdy;
        x.eaAck = ea; x.ebAck = eb; x.eEn = ee; x.eFrame = ef;
        x.eOwner = eo; x.eBusy = ebusy;
        vecs.push_back(x);
    endfunction

    task automatic drive(logic r, logic tk, logic av, logic [63:0] af,
                         logic bv, logic [63:0] bf, logic rdy);
        rst = r; tick = tk; aValid = av; aFrame = af;
        bValid = bv; bFrame = bf; ready = rdy;
    endtask

    task automatic check(string tag, logic ea, logic eb, logic ee, logic [63:0] ef,
                         logic eo, logic ebusy);
        nVec++;
        if ({aAck, bAck, en, frame, owner, busy} !== {ea, eb, ee, ef, eo, ebusy}) begin
            nMis++;
            $display("FAIL %s: got aAck=%b bAck=%b en=%b frame=%h owner=%b busy=%b, want aAck=%b bAck=%b en=%b frame=%h owner=%b busy=%b",
                     tag, aAck, bAck, en, frame, owner, busy, ea, eb, ee, ef, eo, ebusy);
        end
    endtask

    task automatic checkBit(string tag, logic act, logic exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %b, want %b", tag, act, exp);
        end
    endtask

    function automatic void fillTable();
        // Power-up reset; a tie then goes to A first and alternates.
        v("reset",        0,0, 0,0, 0,0, 0,  0,0,0,64'h0,0,0);
        v("idle",         1,0, 0,0, 0,0, 0,  0,0,0,64'h0,0,0);
        for (int k = 0; k < 4; k++) begin
            bit          isB;
            logic [63:0] fr;
            isB = (k % 2) == 1;
            fr  = isB ? 64'h2 : 64'h1;
            v("tie grant",  1,1, 1,64'h1, 1,64'h2, 1,  !isB,isB,1,fr,isB,1);
            v("tie load",   1,1, 1,64'h1, 1,64'h2, 1,  0,0,0,fr,isB,1);
            v("tie hold1",  1,1, 1,64'h1, 1,64'h2, 1,  0,0,0,fr,isB,1);
            v("tie hold2",  1,1, 1,64'h1, 1,64'h2, 1,  0,0,0,fr,isB,1);
            v("tie done",   1,1, 1,64'h1, 1,64'h2, 1,  0,0,0,fr,isB,0);
        end
        // Single request with ready already high.
        v("single grant", 1,0, 1,64'hFF00, 0,0, 1,  1,0,1,64'hFF00,0,1);
        v("single load",  1,0, 0,0, 0,0, 1,  0,0,0,64'hFF00,0,1);
        v("single t1",    1,1, 0,0, 0,0, 1,  0,0,0,64'hFF00,0,1);
        v("single gap",   1,0, 0,0, 0,0, 1,  0,0,0,64'hFF00,0,1);
        v("single t2",    1,1, 0,0, 0,0, 1,  0,0,0,64'hFF00,0,1);
        v("single t3",    1,1, 0,0, 0,0, 1,  0,0,0,64'hFF00,0,0);
        // Ready stall: tick during LOAD must not count.
        v("stall grant",  1,0, 0,0, 1,64'hABCD, 0,  0,1,1,64'hABCD,1,1);
        for (int k = 0; k < 5; k++)
            v("stall wait", 1,(k == 2), 0,0, 0,0, 0,  0,0,1,64'hABCD,1,1);
        v("stall accept", 1,0, 0,0, 0,0, 1,  0,0,0,64'hABCD,1,1);
        v("stall t1",     1,1, 0,0, 0,0, 1,  0,0,0,64'hABCD,1,1);
        v("stall t2",     1,1, 0,0, 0,0, 1,  0,0,0,64'hABCD,1,1);
        v("stall t3",     1,1, 0,0, 0,0, 1,  0,0,0,64'hABCD,1,0);
        // Slow timebase with B waiting through the whole hold.
        v("hold grantA",  1,0, 1,64'h55, 0,0, 1,  1,0,1,64'h55,0,1);
        v("hold load",    1,0, 0,0, 1,64'h66, 1,  0,0,0,64'h55,0,1);
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 9; c++)
                v("hold wait", 1,0, 0,0, 1,64'h66, 1,  0,0,0,64'h55,0,1);
            v("hold tick",   1,1, 0,0, 1,64'h66, 1,  0,0,0,64'h55,0,(t < 2));
        end
        v("hold grantB",  1,0, 0,0, 1,64'h66, 1,  0,1,1,64'h66,1,1);
        v("hold load2",   1,0, 0,0, 0,0, 1,  0,0,0,64'h66,1,1);
        v("hold2 t1",     1,1, 0,0, 0,0, 1,  0,0,0,64'h66,1,1);
        v("hold2 t2",     1,1, 0,0, 0,0, 1,  0,0,0,64'h66,1,1);
        v("hold2 t3",     1,1, 0,0, 0,0, 1,  0,0,0,64'h66,1,0);
        // Withdrawal: A pulses valid only inside HOLD.
        v("wd grantB",    1,0, 0,0, 1,64'h77, 1,  0,1,1,64'h77,1,1);
        v("wd load",      1,0, 0,0, 0,0, 1,  0,0,0,64'h77,1,1);
        v("wd pulse1",    1,1, 1,64'h88, 0,0, 1,  0,0,0,64'h77,1,1);
        v("wd pulse2",    1,0, 1,64'h88, 0,0, 1,  0,0,0,64'h77,1,1);
        v("wd drop",      1,1, 0,0, 0,0, 1,  0,0,0,64'h77,1,1);
        v("wd t3",        1,1, 0,0, 0,0, 1,  0,0,0,64'h77,1,0);
        v("wd idle1",     1,0, 0,0, 0,0, 1,  0,0,0,64'h77,1,0);
        v("wd idle2",     1,0, 0,0, 0,0, 1,  0,0,0,64'h77,1,0);
    endfunction

    initial begin
        nVec = 0;
        nMis = 0;
        drive(0, 0, 0, 64'h0, 0, 64'h0, 0);
        fillTable();
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].tick, vecs[i].av, vecs[i].af,
                  vecs[i].bv, vecs[i].bf, vecs[i].rdy);
            @(posedge clk); #1;
            check(vecs[i].tag, vecs[i].eaAck, vecs[i].ebAck, vecs[i].eEn,
                  vecs[i].eFrame, vecs[i].eOwner, vecs[i].eBusy);
        end

        // Asynchronous reset in the middle of LOAD.
        drive(1, 0, 1, 64'h1234, 0, 64'h0, 0);
        @(posedge clk); #1;
        check("rst preLoad", 1,0,1,64'h1234,0,1);
        aValid = 1'b0;
        #3 rst = 1'b0;
        #1 check("rst midLoad", 0,0,0,64'h0,0,0);
        @(posedge clk); #1;
        check("rst held", 0,0,0,64'h0,0,0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst release", 0,0,0,64'h0,0,0);

        // Zero-tick hold leaves after one tick; main instance still holds.
        drive(1, 0, 0, 64'h0, 1, 64'hA5, 1);
        @(posedge clk); #1;
        check("zero grantB", 0,1,1,64'hA5,1,1);
        checkBit("zero inst grant", zEn, 1'b1);
        drive(1, 0, 0, 64'h0, 0, 64'h0, 1);
        @(posedge clk); #1;
        checkBit("zero inst hold", zBusy, 1'b1);
        drive(1, 1, 0, 64'h0, 0, 64'h0, 1);
        @(posedge clk); #1;
        checkBit("zero inst done", zBusy, 1'b0);
        check("main still hold", 0,0,0,64'hA5,1,1);

        // Asynchronous reset in the middle of HOLD.
        tick = 1'b0;
        #3 rst = 1'b0;
        #1 check("rst midHold", 0,0,0,64'h0,0,0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst idle", 0,0,0,64'h0,0,0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
